// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer.
// Shift-add multiply and restoring divide over a shared 64-bit working register,
// 32 iterations plus one sign-fix cycle; divide special cases finish immediately.
module muldiv_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_t;

  localparam logic [XLEN-1:0] LP_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_cnt;
  logic [2:0]        r_op;
  logic              r_neg;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;

  logic              w_is_m;
  logic [2:0]        w_f3;
  logic              w_accept;
  logic              w_a_sgn;
  logic              w_b_sgn;
  logic              w_neg_a;
  logic              w_neg_b;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_res_neg;
  logic              w_div0;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_spec_val;
  logic [XLEN-1:0]   w_addend;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN+1:0]   w_trial;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_val;
  logic              w_unused;

  assign w_is_m   = (inst[6:0] == 7'b0110011) && (inst[31:25] == 7'b0000001);
  assign w_f3     = inst[14:12];
  assign w_accept = start && w_is_m && ((r_state == ST_IDLE) || (r_state == ST_DONE)) && !flush;

  // Operand signedness per funct3
  always_comb begin
    w_a_sgn = 1'b0;
    w_b_sgn = 1'b0;
    case (w_f3)
      3'b001:  begin w_a_sgn = 1'b1; w_b_sgn = 1'b1; end
      3'b010:  begin w_a_sgn = 1'b1; w_b_sgn = 1'b0; end
      3'b100:  begin w_a_sgn = 1'b1; w_b_sgn = 1'b1; end
      3'b110:  begin w_a_sgn = 1'b1; w_b_sgn = 1'b1; end
      default: begin w_a_sgn = 1'b0; w_b_sgn = 1'b0; end
    endcase
  end

  assign w_neg_a   = w_a_sgn && rs1[XLEN-1];
  assign w_neg_b   = w_b_sgn && rs2[XLEN-1];
  assign w_mag_a   = w_neg_a ? (~rs1 + 1'b1) : rs1;
  assign w_mag_b   = w_neg_b ? (~rs2 + 1'b1) : rs2;
  // Remainder follows the dividend; everything else takes the product/quotient sign
  assign w_res_neg = (w_f3[2] && w_f3[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);

  assign w_div0    = w_f3[2] && (rs2 == '0);
  assign w_ovf     = w_f3[2] && !w_f3[0] && (rs1 == LP_MIN_NEG) && (rs2 == '1);
  assign w_special = w_div0 || w_ovf;

  always_comb begin
    w_spec_val = '0;
    if (w_div0) begin
      w_spec_val = w_f3[1] ? rs1 : '1;
    end else if (w_ovf) begin
      w_spec_val = w_f3[1] ? '0 : LP_MIN_NEG;
    end
  end

  // Multiply step: multiplier sits in the low half and shifts out as the product shifts in
  assign w_addend   = r_acc[0] ? r_b : '0;
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_addend};
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide step: shifted remainder can need XLEN+1 bits, so the trial uses r_acc[63:31]
  assign w_trial    = {1'b0, r_acc[2*XLEN-1:XLEN-1]} - {2'b00, r_b};
  assign w_div_next = w_trial[XLEN+1] ? {r_acc[2*XLEN-2:0], 1'b0}
                                      : {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  assign w_prod = r_neg ? (~r_acc + 1'b1) : r_acc;
  assign w_quot = r_neg ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
  assign w_rem  = r_neg ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_val = '0;
    case (r_op)
      3'b000:                 w_fix_val = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_val = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_val = w_quot;
      default:                w_fix_val = w_rem;
    endcase
  end

  assign w_unused = &{1'b0, inst[24:15], inst[11:7], w_trial[XLEN]};

  // Sequencer: reset, then flush, then per-state behaviour
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_b      <= '0;
      r_acc    <= '0;
    end else if (flush) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
          r_state <= ST_IDLE;
          if (w_accept) begin
            r_op  <= w_f3;
            r_neg <= w_res_neg;
            r_cnt <= '0;
            if (w_special) begin
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
              r_result <= w_spec_val;
            end else if (!w_f3[2]) begin
              r_state <= ST_MUL;
              r_busy  <= 1'b1;
              r_b     <= w_mag_a;
              r_acc   <= {{XLEN{1'b0}}, w_mag_b};
            end else begin
              r_state <= ST_DIV;
              r_busy  <= 1'b1;
              r_b     <= w_mag_b;
              r_acc   <= {{XLEN{1'b0}}, w_mag_a};
            end
          end
        end
        ST_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'(XLEN-1)) r_state <= ST_FIX;
        end
        ST_DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'(XLEN-1)) r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_result <= w_fix_val;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= ST_DONE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule
